// File: rtl/fractal_sync_mp.sv
// fractal_sync_mp: fractal barrier synchronisation node with a parametrised
// slave fan-in.
//
// Slaves (lower-level nodes or cores) raise a sync pulse carrying a barrier
// level. When every participant selected by the participant mask has synced,
// the node does one of three things:
//   - releases the barrier locally when the level says this node is the
//     barrier root,
//   - releases it with an error when the participants disagree on the level,
//   - otherwise forwards the request to the parent and waits for its wake.
//     A watchdog bounds that wait.
// After the release, the node waits until every participant has acknowledged
// its wake. It then returns to idle and acknowledges the parent.
//
// Ports:
//   clk_i, rstn_i    clock, asynchronous active-low reset
//   mask_i           participant mask (bit i = slave i takes part)
//   timeout_i        parent-wait watchdog limit in cycles, 0 disables it
//   slv_sync_i       per-slave sync request pulse
//   slv_level_i      per-slave level, slice i = [i*SLV_WIDTH +: SLV_WIDTH]
//   slv_ack_i        per-slave wake acknowledge pulse
//   slv_wake_o       per-slave wake
//   slv_error_o      per-slave error, valid while wake is asserted
//   mst_sync_o       single-cycle sync request to the parent
//   mst_level_o      level forwarded to the parent
//   mst_ack_o        single-cycle acknowledge to the parent
//   mst_wake_i       wake from the parent
//   mst_error_i      error from the parent, qualified by mst_wake_i

// Per-slave state: sync latch, level register and ack latch.
module fractal_sync_mp_port #(
    parameter int unsigned SLV_WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 part_i,      // this slave takes part
    input  logic                 sync_i,
    input  logic [SLV_WIDTH-1:0] level_i,
    input  logic                 ack_i,
    input  logic                 sync_clr_i,  // barrier released back to idle
    input  logic                 ack_en_i,    // acks are only collected in SYNC
    input  logic                 ack_clr_i,   // entering SYNC
    output logic                 sync_o,
    output logic [SLV_WIDTH-1:0] level_o,
    output logic                 ack_o
);
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_o  <= 1'b0;
            level_o <= '0;
            ack_o   <= 1'b0;
        end else begin
            if (sync_i) level_o <= level_i;
            // A sync arriving on the release cycle belongs to the next
            // barrier, so it overrides the clear.
            if (sync_clr_i)          sync_o <= sync_i & part_i;
            else if (sync_i & part_i) sync_o <= 1'b1;
            if (ack_clr_i)                      ack_o <= 1'b0;
            else if (ack_en_i & ack_i & part_i) ack_o <= 1'b1;
        end
    end
endmodule

module fractal_sync_mp #(
    parameter int unsigned SLV_PORTS = 4,
    parameter int unsigned SLV_WIDTH = 4,
    parameter int unsigned TIMEOUT_W = 8,
    localparam int unsigned MST_WIDTH = (SLV_WIDTH > 1) ? SLV_WIDTH - 1 : 1
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic [SLV_PORTS-1:0]           mask_i,
    input  logic [TIMEOUT_W-1:0]           timeout_i,
    input  logic [SLV_PORTS-1:0]           slv_sync_i,
    input  logic [SLV_PORTS*SLV_WIDTH-1:0] slv_level_i,
    input  logic [SLV_PORTS-1:0]           slv_ack_i,
    output logic [SLV_PORTS-1:0]           slv_wake_o,
    output logic [SLV_PORTS-1:0]           slv_error_o,
    output logic                           mst_sync_o,
    output logic [MST_WIDTH-1:0]           mst_level_o,
    output logic                           mst_ack_o,
    input  logic                           mst_wake_i,
    input  logic                           mst_error_i
);
    if (SLV_PORTS < 2) begin : g_bad_cfg
        $fatal(1, "fractal_sync_mp: SLV_PORTS must be >= 2");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, PROPAGATE = 2'd1, SYNC = 2'd2} state_e;

    state_e                              state_q;
    logic [SLV_PORTS-1:0]                mask_q;
    logic [SLV_PORTS-1:0]                sync_q;
    logic [SLV_PORTS-1:0]                ack_q;
    logic [SLV_PORTS-1:0][SLV_WIDTH-1:0] level_q;
    logic [TIMEOUT_W-1:0]                cnt_q;
    logic [1:0]                          ack_pipe;

    logic                 all_sync, all_ack, sync_done;
    logic                 enter_sync, sync_err;
    logic                 valid_level, ref_found, local_bit;
    logic [SLV_WIDTH-1:0] ref_lvl;

    fractal_sync_mp_port #(.SLV_WIDTH(SLV_WIDTH)) u_port [SLV_PORTS-1:0] (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .part_i     (mask_q),
        .sync_i     (slv_sync_i),
        .level_i    (slv_level_i),
        .ack_i      (slv_ack_i),
        .sync_clr_i (sync_done),
        .ack_en_i   (state_q == SYNC),
        .ack_clr_i  (enter_sync),
        .sync_o     (sync_q),
        .level_o    (level_q),
        .ack_o      (ack_q)
    );

    // An empty mask never completes a barrier.
    assign all_sync  = (|mask_q) & (&(sync_q | ~mask_q));
    assign all_ack   = &(slv_ack_i | ack_q | ~mask_q);
    assign sync_done = (state_q == SYNC) & all_ack;
    assign mst_ack_o = ack_pipe[1];

    // The lowest-index participant provides the reference level.
    always_comb begin
        ref_lvl     = '0;
        ref_found   = 1'b0;
        valid_level = 1'b1;
        for (int i = 0; i < SLV_PORTS; i++) begin
            if (mask_q[i] && !ref_found) begin
                ref_lvl   = level_q[i];
                ref_found = 1'b1;
            end
        end
        for (int i = 0; i < SLV_PORTS; i++) begin
            if (mask_q[i] && (level_q[i] != ref_lvl)) valid_level = 1'b0;
        end
    end

    // Level bit 0 marks this node as the barrier root. The remaining bits
    // are what the parent sees.
    if (SLV_WIDTH > 1) begin : g_lvl
        assign local_bit   = ref_lvl[0];
        assign mst_level_o = ref_lvl[SLV_WIDTH-1 -: MST_WIDTH];
    end else begin : g_lvl1
        assign local_bit   = 1'b1;
        assign mst_level_o = '0;
    end

    // Release decision. mst_wake_i/mst_error_i are sampled at the clock edge
    // that updates slv_wake_o. That gives the parent wake one cycle of
    // latency to the slaves.
    always_comb begin
        enter_sync = 1'b0;
        sync_err   = 1'b0;
        case (state_q)
            IDLE: begin
                if (all_sync && (local_bit || !valid_level)) begin
                    enter_sync = 1'b1;
                    sync_err   = !valid_level;
                end
            end
            PROPAGATE: begin
                if (mst_wake_i) begin
                    enter_sync = 1'b1;
                    sync_err   = mst_error_i;
                end else if ((timeout_i != '0) &&
                             (cnt_q == timeout_i - TIMEOUT_W'(1))) begin
                    enter_sync = 1'b1;
                    sync_err   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            cnt_q       <= '0;
            slv_wake_o  <= '0;
            slv_error_o <= '0;
            mst_sync_o  <= 1'b0;
            ack_pipe    <= '0;
        end else begin
            mst_sync_o <= 1'b0;
            // mst_ack_o is asserted two cycles after the last ack.
            ack_pipe   <= {ack_pipe[0], sync_done};
            // The mask can only change between barriers.
            if ((state_q == IDLE) && (sync_q == '0)) mask_q <= mask_i;
            if (enter_sync) begin
                state_q     <= SYNC;
                slv_wake_o  <= mask_q;
                slv_error_o <= {SLV_PORTS{sync_err}} & mask_q;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (all_sync) begin
                            state_q    <= PROPAGATE;
                            mst_sync_o <= 1'b1;
                            cnt_q      <= '0;
                        end
                    end
                    PROPAGATE: cnt_q <= cnt_q + TIMEOUT_W'(1);
                    SYNC: begin
                        if (all_ack) begin
                            state_q     <= IDLE;
                            slv_wake_o  <= '0;
                            slv_error_o <= '0;
                        end
                    end
                    default: begin
                        state_q     <= IDLE;
                        slv_wake_o  <= '0;
                        slv_error_o <= '0;
                    end
                endcase
            end
        end
    end
endmodule
